// File: rtl/updown_mode_ctrl.sv
// updown_mode_ctrl: debounced button toggle and auto-reverse direction control for an up/down counter
module updown_mode_ctrl #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned DB_CYCLES = 8,
  parameter int unsigned MAX_VAL   = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_n,
  input  logic             auto_en,
  input  logic [WIDTH-1:0] number,
  input  logic             zero,
  output logic             mode,
  output logic             press,
  output logic             mode_chg
);
  localparam int unsigned CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);
  localparam logic [WIDTH-1:0] TOP = WIDTH'(MAX_VAL);
  typedef enum logic [1:0] {S_IDLE, S_PWAIT, S_HELD, S_RWAIT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sync1_q, b_s;
  logic press_q, press_d;
  logic mode_q, mode_d;
  logic chg_q, toggle;
  // two-flop synchronizer for the asynchronous button, idles released (1)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1_q <= 1'b1;
      b_s     <= 1'b1;
    end else begin
      sync1_q <= btn_n;
      b_s     <= sync1_q;
    end
  // debounce FSM: a level must hold for the start sample plus DB_CYCLES more to be accepted
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    case (state_q)
      S_IDLE:
        if (!b_s) begin
          state_d = S_PWAIT;
          cnt_d   = '0;
        end
      S_PWAIT:
        if (b_s) state_d = S_IDLE;
        else if (cnt_q == CNT_MAX) begin
          state_d = S_HELD;
          press_d = 1'b1;
        end else cnt_d = cnt_q + CW'(1);
      S_HELD:
        if (b_s) begin
          state_d = S_RWAIT;
          cnt_d   = '0;
        end
      S_RWAIT:
        if (!b_s) state_d = S_HELD;
        else if (cnt_q == CNT_MAX) state_d = S_IDLE;
        else cnt_d = cnt_q + CW'(1);
      default: state_d = S_IDLE;
    endcase
  end
  // a press and an auto-reverse request in the same cycle merge into one toggle
  always_comb begin
    toggle = press_q | (auto_en & (mode_q ? (number == TOP) : zero));
    mode_d = mode_q ^ toggle;
  end
  // state, debounce count, press pulse, direction and change flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
      mode_q  <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      mode_q  <= mode_d;
      chg_q   <= toggle;
    end
  assign mode     = mode_q;
  assign press    = press_q;
  assign mode_chg = chg_q;
endmodule

// File: doc/updown_mode_ctrl.md
Name: updown_mode_ctrl

Overview:
- Upstream controller for the 4-bit up/down counter. It drives the counter's `mode` input (1 = up, 0 = down).
- Debounces a raw active-low push button. Each clean press toggles `mode`.
- Optional auto-reverse ("ping-pong") uses the counter's `number` and `zero` outputs as feedback: down-to-up at zero, up-to-down at full scale.

Parameters:
- WIDTH, 4: width of the `number` feedback bus.
- DB_CYCLES, 8: consecutive stable clocks required to accept a press or a release. Minimum legal value is 2.
- MAX_VAL, 15: `number` value that triggers up-to-down auto-reverse. Must be ≤ 2^WIDTH-1.

Ports:
- clk, input, 1: single system clock; all state on rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- btn_n, input, 1: raw mechanical button, active low, asynchronous to clk, may bounce.
- auto_en, input, 1: 1 = auto-reverse enabled; synchronous level.
- number, input, WIDTH: current count fed back from the counter.
- zero, input, 1: counter's zero flag, 1 when number == 0.
- mode, output, 1: counter direction, 1 = up, 0 = down.
- press, output, 1: one-clock pulse per accepted debounced press.
- mode_chg, output, 1: one-clock pulse in the cycle after `mode` changes value.

Behaviour:
- Reset: clk and rst_n come in as one clock and an asynchronous, active-low reset.
  - Asserting rst_n = 0 immediately forces: mode = 0, press = 0, mode_chg = 0, FSM = S_IDLE, debounce counter = 0, both synchronizer flops = 1 (released).
  - This applies mid-operation too: any in-progress debounce is discarded.
- Synchronizer: btn_n passes through 2 flops → `b_s`. Only `b_s` is used. `b_s = 0` means pressed.
- Debounce counter `cnt`: width ceil(log2(DB_CYCLES)).
- FSM states and transitions:
  - S_IDLE (released): b_s = 0 → S_PWAIT, cnt = 0.
  - S_PWAIT:
    - b_s = 1 → S_IDLE (bounce rejected, no pulse).
    - b_s = 0 and cnt == DB_CYCLES-1 → S_HELD, press = 1 for the next cycle.
    - Otherwise cnt++.
  - S_HELD: b_s = 1 → S_RWAIT, cnt = 0. Holding the button never re-triggers press.
  - S_RWAIT:
    - b_s = 0 → S_HELD (release bounce, no new press).
    - b_s = 1 and cnt == DB_CYCLES-1 → S_IDLE.
    - Otherwise cnt++.
- Press latency:
  - Edge 1 is the first rising edge that samples btn_n = 0.
  - With btn_n held low from then on, press is high for exactly the cycle after edge DB_CYCLES+3.
- Mode update, evaluated at each rising edge:
  - t_btn = press.
  - t_auto = auto_en & ((mode == 0 & zero) | (mode == 1 & number == MAX_VAL)).
  - If t_btn | t_auto, then mode ← ~mode. A simultaneous button and auto request toggles once, never twice.
- mode_chg: registered; high for one cycle following every mode transition.
- No auto action when:
  - mode = 0 and number == MAX_VAL, or
  - mode = 1 and zero = 1.
- With auto_en = 0, only button presses change mode.
- An auto toggle relies on the counter leaving the trigger value on the next edge. If the trigger condition is still true one cycle after a toggle, the block toggles again; this is legal and documented.

Test Plan (DB_CYCLES = 4, MAX_VAL = 15):
- Reset hold, then release with btn_n = 1 and auto_en = 0 for 20 clocks → mode = 0, press = 0, mode_chg = 0 throughout.
- btn_n low 2 clocks then high, repeated 3 times (bounce) → no press pulse, mode stays 0.
- btn_n low for 30 clocks then high → exactly one press, in the cycle after edge 7. Mode goes 0→1 on the next edge, with mode_chg for 1 cycle. The release produces no pulse.
- auto_en = 1, mode = 0, drive number = 3,2,1,0 with zero = 1 at 0 → mode = 1 after the edge sampling zero. Then drive number up to 15 → mode returns to 0 on the next edge; mode_chg pulses twice in total.
- Press pulse coinciding with an auto condition (mode = 0, zero = 1, auto_en = 1) → single toggle to mode = 1, one mode_chg pulse.
- rst_n asserted in S_PWAIT (btn_n low 3 clocks) → outputs clear asynchronously. After release with btn_n held low, press appears only after a full new DB_CYCLES+3 edges.
